// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO pair.
// MULT/MULTU run a WIDTH-step shift-add loop, DIV/DIVU a WIDTH-step restoring
// divide. Both loops work on unsigned magnitudes, and a final FIX cycle applies
// the sign. MTHI/MTLO and divide-by-zero finish at the accept edge.
//
// Handshake: start is sampled on a rising edge only while busy=0. A legal op
// is accepted at that edge. A start seen while busy=1, or a start with a
// reserved op, is dropped with no effect, and the requester must re-issue it.
// done pulses for exactly one cycle after hi/lo change. busy drops in that
// same cycle, so a new start may be presented while done=1.
module hilo_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   // work_hi/work_lo hold the running product, or the remainder and quotient.
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
   logic             is_div;
   logic             neg_q;       // negate product or quotient in FIX
   logic             neg_r;       // negate remainder in FIX

   logic             signed_op;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // Operand magnitudes for the accept edge, plus the datapath for one loop step and for FIX.
   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      sign_a    = signed_op & a[WIDTH-1];
      sign_b    = signed_op & b[WIDTH-1];
      abs_a     = sign_a ? (~a + 1'b1) : a;
      abs_b     = sign_b ? (~b + 1'b1) : b;
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, opnd};
      prod      = {work_hi, work_lo};
      prod_fix  = neg_q ? (~prod + 1'b1) : prod;
      quo_fix   = neg_q ? (~work_lo + 1'b1) : work_lo;
      rem_fix   = neg_r ? (~work_hi + 1'b1) : work_hi;
   end

   // Sequencer FSM and the architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         work_hi     <= '0;
         work_lo     <= '0;
         opnd        <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: begin
                        hi          <= a;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                     end
                     OP_MTLO: begin
                        lo          <= a;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                     end
                     OP_MULT, OP_MULTU: begin
                        work_hi     <= '0;
                        work_lo     <= abs_b;
                        opnd        <= abs_a;
                        is_div      <= 1'b0;
                        neg_q       <= sign_a ^ sign_b;
                        neg_r       <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (b == '0) begin
                           hi          <= a;
                           lo          <= '1;
                           div_by_zero <= 1'b1;
                           done        <= 1'b1;
                        end else begin
                           work_hi     <= '0;
                           work_lo     <= abs_a;
                           opnd        <= abs_b;
                           is_div      <= 1'b1;
                           neg_q       <= sign_a ^ sign_b;
                           neg_r       <= sign_a;
                           cnt         <= '0;
                           busy        <= 1'b1;
                           div_by_zero <= 1'b0;
                           state       <= DIV;
                        end
                     end
                     default: begin
                        // Reserved encodings are dropped silently.
                     end
                  endcase
               end
            end
            MUL: begin
               work_hi <= mul_sum[WIDTH:1];
               work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  cnt   <= '0;
                  state <= FIX;
               end
            end
            DIV: begin
               if (!div_trial[WIDTH]) begin
                  work_hi <= div_trial[WIDTH-1:0];
                  work_lo <= {work_lo[WIDTH-2:0], 1'b1};
               end else begin
                  work_hi <= {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
                  work_lo <= {work_lo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  cnt   <= '0;
                  state <= FIX;
               end
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: a vector table of directed ops, then randomly
// generated ops checked against an arithmetic model, then the hand-written
// corner cases. The corner cases are an ignored start while busy, a reserved
// op, and a reset mid-operation.
module tb_hilo_muldiv_ctrl;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          div_by_zero;

   int checks   = 0;
   int failures = 0;
   logic [2*W:0] exp_q[$];   // {hi, lo, div_by_zero}

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2*W:0] res;
      int           lat;
      int           nbusy;
   } vec_t;

   vec_t tbl[12];

   // Clock.
   always #5 clk = ~clk;

   hilo_muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint      p, q, r;
      logic [63:0] u;
      logic [63:0] qq;
      logic [63:0] rr;
      case (o)
         3'b000: begin p = longint'($signed(x)) * longint'($signed(y)); return {p, 1'b0}; end
         3'b001: begin u = {32'd0, x} * {32'd0, y}; return {u, 1'b0}; end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF, 1'b1};
            if (o == 3'b010) begin
               q = longint'($signed(x)) / longint'($signed(y));
               r = longint'($signed(x)) % longint'($signed(y));
               qq = q; rr = r;
            end else begin
               qq = {32'd0, x} / {32'd0, y};
               rr = {32'd0, x} % {32'd0, y};
            end
            return {rr[31:0], qq[31:0], 1'b0};
         end
      endcase
   endfunction

   // Driver: presents start at the current negedge, tracks latency, busy cycles
   // and hi/lo hold, then pops the scoreboard when done arrives. A non-zero
   // inj_cycle re-issues a DIVU start at that cycle to check it is ignored.
   task automatic run_op(input string name, input logic [2:0] op_v, input logic [W-1:0] a_v,
                         input logic [W-1:0] b_v, input logic [2*W:0] exp_res,
                         input int exp_lat, input int exp_busy, input int inj_cycle);
      int lat;
      int nbusy;
      logic hold_bad;
      logic [W-1:0] oh;
      logic [W-1:0] ol;
      logic [2*W:0] e;
      start = 1'b1; op = op_v; a = a_v; b = b_v;
      exp_q.push_back(exp_res);
      oh = hi; ol = lo; lat = 0; nbusy = 0; hold_bad = 1'b0;
      do begin
         @(negedge clk);
         start = 1'b0; a = $urandom; b = $urandom;
         lat++;
         if (lat == inj_cycle) begin
            start = 1'b1; op = 3'b011; b = 32'd3;
         end
         if (busy) nbusy++;
         if (!done && (hi !== oh || lo !== ol)) hold_bad = 1'b1;
      end while (!done && lat < 100);
      check({name, "_latency"}, 65'(lat), 65'(exp_lat));
      check({name, "_busy_cycles"}, 65'(nbusy), 65'(exp_busy));
      check({name, "_hilo_hold"}, 65'(hold_bad), 65'(0));
      e = exp_q.pop_front();
      check({name, "_result"}, {hi, lo, div_by_zero}, e);
   endtask

   initial begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;
      logic [2*W:0] snap;
      int           ndone, nbusy;

      tbl[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 34, 33};
      tbl[1]  = '{3'b000, 32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}, 34, 33};
      tbl[2]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000, 1'b0}, 34, 33};
      tbl[3]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 34, 33};
      tbl[4]  = '{3'b011, 32'd7,         32'd2,         {32'h0000_0001, 32'h0000_0003, 1'b0}, 34, 33};
      tbl[5]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000, 1'b0}, 34, 33};
      tbl[6]  = '{3'b010, 32'd5,         32'd0,         {32'h0000_0005, 32'hFFFF_FFFF, 1'b1}, 1, 0};
      tbl[7]  = '{3'b101, 32'h0000_1234, 32'd9,         {32'h0000_0005, 32'h0000_1234, 1'b0}, 1, 0};
      tbl[8]  = '{3'b100, 32'h0000_CAFE, 32'd0,         {32'h0000_CAFE, 32'h0000_1234, 1'b0}, 1, 0};
      tbl[9]  = '{3'b011, 32'h0000_0100, 32'd0,         {32'h0000_0100, 32'hFFFF_FFFF, 1'b1}, 1, 0};
      tbl[10] = '{3'b100, 32'h0000_DEAD, 32'd0,         {32'h0000_DEAD, 32'hFFFF_FFFF, 1'b0}, 1, 0};
      tbl[11] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0000, 32'h0000_0001, 1'b0}, 34, 33};

      // Reset.
      reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 65'(busy), 65'(0));
      check("reset_done", 65'(done), 65'(0));
      check("reset_hi", 65'(hi), 65'(0));
      check("reset_lo", 65'(lo), 65'(0));
      check("reset_dbz", 65'(div_by_zero), 65'(0));

      // Table: every row issued in the done cycle of the one before.
      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                tbl[i].lat, tbl[i].nbusy, 0);

      // Random ops against the arithmetic model, with an idle cycle between them.
      for (int i = 0; i < 6; i++) begin
         ro = 3'($urandom_range(0, 3));
         rx = $urandom;
         ry = (i == 4) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom);
         @(negedge clk);
         if (ro >= 3'b010 && ry == 0)
            run_op($sformatf("rnd%0d", i), ro, rx, ry, model(ro, rx, ry), 1, 0, 0);
         else
            run_op($sformatf("rnd%0d", i), ro, rx, ry, model(ro, rx, ry), 34, 33, 0);
      end

      // A DIVU start while MULTU is busy must be ignored.
      @(negedge clk);
      run_op("ignored_start", 3'b001, 32'h10, 32'h20, {32'h0, 32'h200, 1'b0}, 34, 33, 5);

      // A reserved op must leave everything untouched, including a set div_by_zero.
      @(negedge clk);
      run_op("dbz_setup", 3'b011, 32'h77, 32'd0, {32'h77, 32'hFFFF_FFFF, 1'b1}, 1, 0, 0);
      snap = {hi, lo, div_by_zero};
      ndone = 0; nbusy = 0;
      start = 1'b1; op = 3'b110; a = 32'h5555; b = 32'd1;
      @(negedge clk);
      op = 3'b111;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("reserved_done", 65'(ndone), 65'(0));
      check("reserved_busy", 65'(nbusy), 65'(0));
      check("reserved_state", {hi, lo, div_by_zero}, snap);

      // Reset mid-MULTU, with a start in the reset cycle: reset wins.
      start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_reset_busy", 65'(busy), 65'(1));
      reset = 1'b1; start = 1'b1; op = 3'b001;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("midreset_busy", 65'(busy), 65'(0));
      check("midreset_done", 65'(done), 65'(0));
      check("midreset_hilo", {hi, lo, div_by_zero}, 65'(0));
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("midreset_no_done", 65'(ndone), 65'(0));
      check("midreset_hilo_after", {hi, lo, div_by_zero}, 65'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
